bin_to_bcd_display: RTL and testbench

- Upstream feeder for the 4-digit multiplexed seven-segment controller.
- Accepts an unsigned binary value and converts it to four BCD digits, one shift-add-3 (double-dabble) iteration per clock.
- Produces registered `digits`, `decimal_points` and `enables` buses that wire directly to the controller's inputs.
- Applies leading-zero blanking and saturates out-of-range values.

---
 rtl/bin_to_bcd_display.sv | 211 +++++++++++++++++++++
 tb/tb_bin_to_bcd_display.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_display.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_display
//
// Purpose:
//   Upstream feeder for a 4-digit multiplexed seven-segment controller.
//   Converts an unsigned binary value into four BCD digits using the
//   shift-add-3 (double-dabble) algorithm, one iteration per clock.
//   Values above 9999 saturate to 9999 and raise `overflow`. Leading zero
//   digits can be blanked through `enables`. All display outputs are
//   registered and only change on the cycle `done` pulses, so the display
//   never shows a partially converted number.
//
// Parameters:
//   WIDTH          bit width of `value` (4..14); a conversion takes WIDTH
//                  clock cycles.
//   BLANK_LEADING  1 = blank leading zero digits via `enables`,
//                  0 = all four digits enabled after every conversion.
//
// Ports:
//   clk             system clock, all state changes on the rising edge
//   reset           asynchronous, active-high reset
//   value           binary value to display, sampled on an accepted load
//   load            start request, accepted only while busy is low
//   dp_sel          decimal-point mask, sampled together with value
//   digits          BCD result, thousands in [15:12] ... units in [3:0]
//   decimal_points  dp_sel captured at the accepted load
//   enables         per-digit enable after blanking, bit 0 always set
//   busy            high while a conversion is in progress
//   done            one-cycle pulse when the outputs take a new result
//   overflow        high when the last accepted value exceeded 9999
// -----------------------------------------------------------------------------
module bin_to_bcd_display #(
    parameter int WIDTH         = 14,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic [3:0]       dp_sel,
    output logic [15:0]      digits,
    output logic [3:0]       decimal_points,
    output logic [3:0]       enables,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    // Counter must be able to hold WIDTH after the final increment.
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    // Saturated input; only reachable when WIDTH is large enough to
    // represent numbers above 9999, so the truncating cast is harmless.
    localparam logic [WIDTH-1:0] SAT_VALUE = WIDTH'(9999);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic [15:0]      bcd_q, bcd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       dp_hold_q, dp_hold_d;
    logic             ovf_pend_q, ovf_pend_d;

    logic [15:0]      digits_q, digits_d;
    logic [3:0]       dp_out_q, dp_out_d;
    logic [3:0]       en_q, en_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [15:0]         bcd_adj;
    logic [WIDTH+15:0]   shifted;
    logic [15:0]         bcd_shift;
    logic [WIDTH-1:0]    bin_shift;
    logic [3:0]          en_calc;
    logic [15:0]         value_ext;
    logic                value_over;

    // Saturation test is done in 16 bits so 9999 is representable
    // regardless of WIDTH.
    always_comb begin
        value_ext  = 16'(value);
        value_over = (value_ext > 16'd9999);
    end

    // One double-dabble step: correct every nibble that would overflow
    // past 9 after doubling, then shift the whole {bcd, bin} register.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted   = {bcd_adj, bin_q} << 1;
        bcd_shift = shifted[WIDTH+15:WIDTH];
        bin_shift = shifted[WIDTH-1:0];
    end

    // Leading-zero blanking on the value about to be published. A digit
    // stays lit if it is nonzero, if any digit to its left is lit, or if a
    // decimal point sits at or above it, so "0.5" keeps its leading zero.
    always_comb begin
        en_calc    = 4'b0001;
        en_calc[3] = (bcd_shift[15:12] != 4'd0) | (dp_hold_q[3] != 1'b0);
        en_calc[2] = (bcd_shift[11:8]  != 4'd0) | en_calc[3] | (|dp_hold_q[3:2]);
        en_calc[1] = (bcd_shift[7:4]   != 4'd0) | en_calc[2] | (|dp_hold_q[3:1]);
        if (!BLANK_LEADING) begin
            en_calc = 4'b1111;
        end
    end

    // Next-state logic. Outputs only move on the final iteration; a load
    // seen outside IDLE is dropped without any side effect.
    always_comb begin
        state_d    = state_q;
        bin_d      = bin_q;
        bcd_d      = bcd_q;
        cnt_d      = cnt_q;
        dp_hold_d  = dp_hold_q;
        ovf_pend_d = ovf_pend_q;
        digits_d   = digits_q;
        dp_out_d   = dp_out_q;
        en_d       = en_q;
        ovf_d      = ovf_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (load) begin
                    if (value_over) begin
                        bin_d      = SAT_VALUE;
                        ovf_pend_d = 1'b1;
                    end else begin
                        bin_d      = value;
                        ovf_pend_d = 1'b0;
                    end
                    dp_hold_d = dp_sel;
                    bcd_d     = 16'h0000;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end

            SHIFT: begin
                bin_d = bin_shift;
                bcd_d = bcd_shift;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    digits_d = bcd_shift;
                    dp_out_d = dp_hold_q;
                    en_d     = en_calc;
                    ovf_d    = ovf_pend_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers. Reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bin_q      <= '0;
            bcd_q      <= 16'h0000;
            cnt_q      <= '0;
            dp_hold_q  <= 4'b0000;
            ovf_pend_q <= 1'b0;
            digits_q   <= 16'h0000;
            dp_out_q   <= 4'b0000;
            en_q       <= 4'b0001;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            dp_hold_q  <= dp_hold_d;
            ovf_pend_q <= ovf_pend_d;
            digits_q   <= digits_d;
            dp_out_q   <= dp_out_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign digits         = digits_q;
    assign decimal_points = dp_out_q;
    assign enables        = en_q;
    assign overflow       = ovf_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_display
//
// Purpose:
//   Self-checking bench for bin_to_bcd_display with default parameters.
//   A behavioural model derives the expected display outputs with decimal
//   arithmetic and a simple cycle countdown; a compare process checks the
//   DUT against it on every falling edge, and directed cases pin both the
//   DUT and the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_display;

    localparam int W = 14;
    localparam bit BLANK = 1'b1;

    logic          clk;
    logic          reset;
    logic [W-1:0]  value;
    logic          load;
    logic [3:0]    dp_sel;
    logic [15:0]   digits;
    logic [3:0]    decimal_points;
    logic [3:0]    enables;
    logic          busy;
    logic          done;
    logic          overflow;

    int total = 0;
    int bad   = 0;

    bin_to_bcd_display #(
        .WIDTH(W),
        .BLANK_LEADING(BLANK)
    ) dut (
        .clk(clk),
        .reset(reset),
        .value(value),
        .load(load),
        .dp_sel(dp_sel),
        .digits(digits),
        .decimal_points(decimal_points),
        .enables(enables),
        .busy(busy),
        .done(done),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison primitive: every check in the bench goes through here.
    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected display content for a saturated decimal number.
    function automatic logic [15:0] toBcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    // Blanking rule expressed digit by digit from the left.
    function automatic logic [3:0] expEnables(input logic [15:0] d, input logic [3:0] dp);
        logic [3:0] e;
        bit hi;
        e  = 4'b0001;
        hi = 1'b0;
        for (int i = 3; i >= 1; i--) begin
            e[i] = (d[4*i +: 4] != 4'd0) || hi || ((dp >> i) != 4'd0);
            hi   = e[i];
        end
        return BLANK ? e : 4'b1111;
    endfunction

    // Behavioural model: a countdown of W edges after an accepted load,
    // then the precomputed result is published with a one-cycle done.
    logic [15:0] mDigits = 16'h0000;
    logic [3:0]  mDp     = 4'b0000;
    logic [3:0]  mEn     = 4'b0001;
    logic        mOvf    = 1'b0;
    logic        mBusy   = 1'b0;
    logic        mDone   = 1'b0;
    int          mLeft   = 0;
    logic [15:0] pDigits;
    logic [3:0]  pDp;
    logic [3:0]  pEn;
    logic        pOvf;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mDigits = 16'h0000;
            mDp     = 4'b0000;
            mEn     = 4'b0001;
            mOvf    = 1'b0;
            mBusy   = 1'b0;
            mDone   = 1'b0;
            mLeft   = 0;
        end else begin
            mDone = 1'b0;
            if (mBusy) begin
                mLeft--;
                if (mLeft == 0) begin
                    mDigits = pDigits;
                    mDp     = pDp;
                    mEn     = pEn;
                    mOvf    = pOvf;
                    mDone   = 1'b1;
                    mBusy   = 1'b0;
                end
            end else if (load) begin
                int s;
                s       = int'(value);
                pOvf    = (s > 9999);
                if (s > 9999) s = 9999;
                pDigits = toBcd(s);
                pDp     = dp_sel;
                pEn     = expEnables(pDigits, dp_sel);
                mBusy   = 1'b1;
                mLeft   = W;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkVal("cyc_digits", digits, mDigits);
        checkVal("cyc_dp", 16'(decimal_points), 16'(mDp));
        checkVal("cyc_enables", 16'(enables), 16'(mEn));
        checkVal("cyc_overflow", 16'(overflow), 16'(mOvf));
        checkVal("cyc_busy", 16'(busy), 16'(mBusy));
        checkVal("cyc_done", 16'(done), 16'(mDone));
    end

    // Present a one-cycle load pulse; returns just after the accepting edge.
    task automatic applyStimulus(input int v, input logic [3:0] dp);
        @(posedge clk);
        #1;
        value  = W'(v);
        dp_sel = dp;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    // Bounded wait for done; reports edges since the load and busy cycles.
    task automatic waitDone(output int edges, output int busyCycles);
        int n;
        bit got;
        n          = 0;
        got        = 1'b0;
        busyCycles = 0;
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (busy) busyCycles++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done expected done within 60 cycles");
        end
        edges = n - 1;
    endtask

    // Direct literal check of the visible outputs.
    task automatic checkOutput(input string tag, input logic [15:0] expDigits,
                               input logic [3:0] expDp, input logic [3:0] expEn,
                               input logic expOvf);
        checkVal({tag, "_digits"}, digits, expDigits);
        checkVal({tag, "_dp"}, 16'(decimal_points), 16'(expDp));
        checkVal({tag, "_enables"}, 16'(enables), 16'(expEn));
        checkVal({tag, "_overflow"}, 16'(overflow), 16'(expOvf));
    endtask

    initial begin
        int edges;
        int busyCycles;
        int doneSeen;

        reset  = 1'b1;
        load   = 1'b0;
        value  = '0;
        dp_sel = 4'b0000;
        #2;
        checkOutput("reset", 16'h0000, 4'b0000, 4'b0001, 1'b0);
        checkVal("reset_busy", 16'(busy), 16'd0);
        checkVal("reset_done", 16'(done), 16'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic conversion with latency and busy-length checks.
        applyStimulus(1234, 4'b0000);
        waitDone(edges, busyCycles);
        checkVal("latency_edges", 16'(edges), 16'(W));
        checkVal("busy_cycles", 16'(busyCycles), 16'(W));
        checkOutput("v1234", 16'h1234, 4'b0000, 4'b1111, 1'b0);
        checkVal("model_1234", mDigits, 16'h1234);

        applyStimulus(7, 4'b0000);
        waitDone(edges, busyCycles);
        checkOutput("v7", 16'h0007, 4'b0000, 4'b0001, 1'b0);

        applyStimulus(0, 4'b0000);
        waitDone(edges, busyCycles);
        checkOutput("v0", 16'h0000, 4'b0000, 4'b0001, 1'b0);

        applyStimulus(5, 4'b0100);
        waitDone(edges, busyCycles);
        checkOutput("v5dp", 16'h0005, 4'b0100, 4'b0111, 1'b0);
        checkVal("model_en_5dp", 16'(mEn), 16'(4'b0111));

        // Saturation, then a normal value clears overflow.
        applyStimulus(12000, 4'b0000);
        waitDone(edges, busyCycles);
        checkOutput("v12000", 16'h9999, 4'b0000, 4'b1111, 1'b1);
        checkVal("model_ovf", 16'(mOvf), 16'd1);

        applyStimulus(42, 4'b0000);
        waitDone(edges, busyCycles);
        checkOutput("v42", 16'h0042, 4'b0000, 4'b0011, 1'b0);

        applyStimulus(9999, 4'b0001);
        waitDone(edges, busyCycles);
        checkOutput("v9999", 16'h9999, 4'b0001, 4'b1111, 1'b0);

        // Load while busy is ignored; load in the done cycle is accepted.
        applyStimulus(300, 4'b0000);
        repeat (4) @(posedge clk);
        #1;
        value  = W'(55);
        dp_sel = 4'b1000;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        waitDone(edges, busyCycles);
        checkOutput("v300", 16'h0300, 4'b0000, 4'b0111, 1'b0);
        value  = W'(77);
        dp_sel = 4'b0000;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
        @(negedge clk);
        checkVal("busy_after_done_load", 16'(busy), 16'd1);
        waitDone(edges, busyCycles);
        checkOutput("v77", 16'h0077, 4'b0000, 4'b0011, 1'b0);

        // Reset mid-conversion aborts without a done pulse.
        applyStimulus(9876, 4'b0000);
        repeat (7) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset", 16'h0000, 4'b0000, 4'b0001, 1'b0);
        checkVal("midreset_busy", 16'(busy), 16'd0);
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        doneSeen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkVal("no_done_after_reset", 16'(doneSeen), 16'd0);

        applyStimulus(9876, 4'b0000);
        waitDone(edges, busyCycles);
        checkOutput("v9876", 16'h9876, 4'b0000, 4'b1111, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
